// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the multdiv issue controller.
//   md_state_e : controller state encoding
//   md_cause_e : why a writeback result is flagged, if at all
//   TIMEOUT_DEFAULT : default watchdog limit in cycles after START
package multdiv_issue_ctrl_pkg;

  localparam int TIMEOUT_DEFAULT = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } md_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_MD      = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } md_cause_e;

  function automatic logic cause_is_exc(input md_cause_e cause);
    return cause != CAUSE_NONE;
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_watchdog.sv
// Watchdog counter for an in-flight multdiv op.
//   clock, reset_n : clock, async active-low reset
//   clear_i        : reset the count to zero (op accepted)
//   enable_i       : count this cycle (START, BUSY, DRAIN)
//   expire_o       : count has reached TIMEOUT-1
// The count saturates at all-ones rather than wrapping, so a stuck
// enable can never make expire_o fire a second time by accident.
module md_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int                CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire_o = (count_q == LIMIT);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between execute and the multdiv unit. Accepts one op,
// pulses the matching start strobe, holds operands, stalls upstream until
// the unit answers (or the watchdog expires), then holds the result for
// writeback until acknowledged. Flush squashes the op in flight.
//
// Ports:
//   clock, reset_n          clock, async active-low reset
//   op_valid/op_is_div/op_a/op_b/op_rd   op from execute
//   op_ready                controller idle, can accept
//   flush                   squash in-flight op
//   md_operandA/B           registered operands to multdiv
//   ctrl_MULT/ctrl_DIV      one-cycle start pulses
//   md_result/md_exception/md_ready      multdiv response
//   stall                   hold upstream pipeline
//   wb_valid/wb_data/wb_rd/wb_exception/wb_timeout  writeback result
//   wb_ack                  writeback consumed result
//
// state | meaning
// IDLE  | waiting for op_valid; op_ready=1
// START | start pulse on ctrl_MULT/ctrl_DIV; md_ready is stale, ignored
// BUSY  | waiting for md_ready or watchdog expiry
// DONE  | result held for writeback until wb_ack or flush
// DRAIN | op flushed; wait for md_ready/expiry, discard result
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RD_W-1:0]  op_rd,
  output logic             op_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] md_operandA,
  output logic [WIDTH-1:0] md_operandB,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_ready,
  output logic             stall,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic [RD_W-1:0]  wb_rd,
  output logic             wb_exception,
  output logic             wb_timeout,
  input  logic             wb_ack
);

  md_state_e        state_q, state_d;
  logic             accept, capture, wd_enable, wd_expire;
  logic [WIDTH-1:0] opa_q, opb_q, wb_data_q;
  logic [RD_W-1:0]  rd_q, wb_rd_q;
  logic             ctrl_mult_q, ctrl_div_q, op_ready_q, wb_valid_q;
  md_cause_e        cause_q;

  assign accept    = (state_q == ST_IDLE) && op_valid;
  assign capture   = (state_q == ST_BUSY) && (state_d == ST_DONE);
  assign wd_enable = (state_q == ST_START) || (state_q == ST_BUSY) ||
                     (state_q == ST_DRAIN);

  md_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (accept),
    .enable_i (wd_enable),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (op_valid) state_d = ST_START;
      ST_START: state_d = flush ? ST_DRAIN : ST_BUSY;
      ST_BUSY: begin
        // Flush beats a same-cycle response; if the unit has already
        // answered (or given up) there is nothing left to drain.
        if (flush)                       state_d = (md_ready || wd_expire) ? ST_IDLE : ST_DRAIN;
        else if (md_ready || wd_expire)  state_d = ST_DONE;
      end
      ST_DONE:  if (flush || wb_ack) state_d = ST_IDLE;
      ST_DRAIN: if (md_ready || wd_expire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_ready_q  <= 1'b1;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      rd_q        <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      cause_q     <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      op_ready_q  <= (state_d == ST_IDLE);
      ctrl_mult_q <= accept && !op_is_div;
      ctrl_div_q  <= accept && op_is_div;
      wb_valid_q  <= (state_d == ST_DONE);
      if (accept) begin
        opa_q <= op_a;
        opb_q <= op_b;
        rd_q  <= op_rd;
      end
      if (capture) begin
        wb_rd_q <= rd_q;
        // md_ready wins over a same-cycle expiry
        if (md_ready) begin
          wb_data_q <= md_result;
          cause_q   <= md_exception ? CAUSE_MD : CAUSE_NONE;
        end else begin
          wb_data_q <= '0;
          cause_q   <= CAUSE_TIMEOUT;
        end
      end
    end
  end

  assign op_ready     = op_ready_q;
  assign stall        = (state_q != ST_IDLE) || op_valid;
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign ctrl_MULT    = ctrl_mult_q;
  assign ctrl_DIV     = ctrl_div_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_exception = cause_is_exc(cause_q);
  assign wb_timeout   = (cause_q == CAUSE_TIMEOUT);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;
  localparam int WIDTH   = 32;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 40;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             op_valid = 1'b0, op_is_div = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic [RD_W-1:0]  op_rd = '0;
  logic             op_ready, flush = 1'b0;
  logic [WIDTH-1:0] md_operandA, md_operandB;
  logic             ctrl_MULT, ctrl_DIV;
  logic [WIDTH-1:0] md_result = '0;
  logic             md_exception = 1'b0, md_ready = 1'b0;
  logic             stall, wb_valid;
  logic [WIDTH-1:0] wb_data;
  logic [RD_W-1:0]  wb_rd;
  logic             wb_exception, wb_timeout;
  logic             wb_ack = 1'b0;

  always #5 clock = ~clock;

  multdiv_issue_ctrl #(.WIDTH(WIDTH), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .op_valid(op_valid), .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .op_ready(op_ready), .flush(flush),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_exception(wb_exception), .wb_timeout(wb_timeout), .wb_ack(wb_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an op is either in flight (with its age in
  // cycles since START, age 1 = START) or its result is pending writeback.
  bit               m_infl, m_drain, m_pend, m_div, m_exc, m_to;
  int               m_age;
  logic [WIDTH-1:0] m_a, m_b, m_data;
  logic [RD_W-1:0]  m_rd, m_wbrd;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_infl = 0; m_drain = 0; m_pend = 0; m_div = 0; m_exc = 0; m_to = 0;
      m_age = 0; m_a = '0; m_b = '0; m_data = '0; m_rd = '0; m_wbrd = '0;
    end else if (m_pend) begin
      if (flush || wb_ack) m_pend = 0;
    end else if (!m_infl) begin
      if (op_valid) begin
        m_infl = 1; m_age = 1; m_drain = 0; m_div = op_is_div;
        m_a = op_a; m_b = op_b; m_rd = op_rd;
      end
    end else if (m_age == 1) begin
      m_age = 2;
      if (flush) m_drain = 1;
    end else begin
      bit tmo;
      tmo = (m_age >= TIMEOUT);
      if (flush && !m_drain) begin
        if (md_ready || tmo) m_infl = 0;
        else begin m_drain = 1; m_age++; end
      end else if (md_ready || tmo) begin
        m_infl = 0;
        if (!m_drain) begin
          m_pend = 1; m_wbrd = m_rd;
          m_data = md_ready ? md_result : '0;
          m_exc  = md_ready ? md_exception : 1'b1;
          m_to   = !md_ready;
        end
      end else begin
        m_age++;
      end
    end
  end

  int mult_pulses = 0, div_pulses = 0, wbv_cycles = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      check("op_ready",    64'(op_ready),    64'(!m_infl && !m_pend));
      check("stall",       64'(stall),       64'(m_infl || m_pend || op_valid));
      check("ctrl_MULT",   64'(ctrl_MULT),   64'(m_infl && m_age == 1 && !m_div));
      check("ctrl_DIV",    64'(ctrl_DIV),    64'(m_infl && m_age == 1 && m_div));
      check("wb_valid",    64'(wb_valid),    64'(m_pend));
      check("md_operandA", 64'(md_operandA), 64'(m_a));
      check("md_operandB", 64'(md_operandB), 64'(m_b));
      if (m_pend) begin
        check("wb_data",      64'(wb_data),      64'(m_data));
        check("wb_rd",        64'(wb_rd),        64'(m_wbrd));
        check("wb_exception", 64'(wb_exception), 64'(m_exc || m_to));
        check("wb_timeout",   64'(wb_timeout),   64'(m_to));
      end
      if (ctrl_MULT) mult_pulses++;
      if (ctrl_DIV)  div_pulses++;
      if (wb_valid)  wbv_cycles++;
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  // Returns one cycle after acceptance, i.e. during START.
  task automatic issue(input bit div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [RD_W-1:0] rd);
    op_valid = 1; op_is_div = div; op_a = a; op_b = b; op_rd = rd;
    cyc();
    op_valid = 0;
  endtask

  task automatic respond(input logic [WIDTH-1:0] res, input bit exc);
    md_ready = 1; md_result = res; md_exception = exc;
    cyc();
    md_ready = 0; md_exception = 0;
  endtask

  task automatic ack();
    wb_ack = 1; cyc(); wb_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p_m, p_d, w0, n;

    // Reset state
    repeat (2) cyc();
    check("rst op_ready", 64'(op_ready), 64'(1));
    check("rst stall",    64'(stall),    64'(0));
    check("rst wb_valid", 64'(wb_valid), 64'(0));
    check("rst opA",      64'(md_operandA), 64'(0));
    reset_n = 1;
    cyc();

    // mult 7*3 with stale md_ready during START
    p_m = mult_pulses; p_d = div_pulses;
    issue(0, 7, 3, 5);
    md_ready = 1; md_result = 32'hdead;
    cyc();
    md_ready = 0;
    cyc();
    respond(21, 0);
    check("mult wb_data", 64'(wb_data), 64'd21);
    check("mult wb_rd",   64'(wb_rd),   64'd5);
    check("mult wb_exc",  64'(wb_exception), 64'(0));
    check("mult pulses",  64'(mult_pulses - p_m), 64'(1));
    check("mult no div",  64'(div_pulses - p_d),  64'(0));
    // op_valid during DONE: not accepted
    op_valid = 1; op_a = 9;
    cyc();
    check("done stall",    64'(stall),    64'(1));
    check("done op_ready", 64'(op_ready), 64'(0));
    op_valid = 0;
    ack();
    check("ack op_ready", 64'(op_ready), 64'(1));
    check("ack opA kept", 64'(md_operandA), 64'd7);

    // div 7/3
    p_m = mult_pulses; p_d = div_pulses;
    issue(1, 7, 3, 3);
    cyc();
    respond(2, 0);
    check("div wb_data", 64'(wb_data), 64'd2);
    check("div pulses",  64'(div_pulses - p_d),  64'(1));
    check("div no mult", 64'(mult_pulses - p_m), 64'(0));
    ack();

    // div 5/0 exception
    issue(1, 5, 0, 4);
    cyc();
    respond(0, 1);
    check("div0 wb_exc", 64'(wb_exception), 64'(1));
    check("div0 wb_to",  64'(wb_timeout),   64'(0));
    ack();

    // Timeout: wb_valid exactly TIMEOUT cycles after START
    issue(0, 1, 2, 6);
    n = 0;
    while (!wb_valid && n < 100) begin cyc(); n++; end
    check("tmo latency", 64'(n), 64'd40);
    check("tmo wb_to",   64'(wb_timeout),   64'(1));
    check("tmo wb_exc",  64'(wb_exception), 64'(1));
    check("tmo wb_data", 64'(wb_data),      64'(0));
    ack();

    // Flush in BUSY, md_ready 3 cycles later
    issue(0, 4, 4, 7);
    cyc();
    w0 = wbv_cycles;
    flush = 1; cyc(); flush = 0;
    cyc(); cyc();
    respond(99, 0);
    check("flush op_ready", 64'(op_ready), 64'(1));
    check("flush no wb",    64'(wbv_cycles - w0), 64'(0));

    // Flush and md_ready together in BUSY: flush wins
    issue(1, 8, 2, 8);
    cyc();
    flush = 1; md_ready = 1; md_result = 4;
    cyc();
    flush = 0; md_ready = 0;
    check("flush+rdy op_ready", 64'(op_ready), 64'(1));
    check("flush+rdy wb_valid", 64'(wb_valid), 64'(0));

    // Flush in START: pulse still issued, then drain
    p_m = mult_pulses;
    issue(0, 3, 3, 9);
    flush = 1; cyc(); flush = 0;
    check("start flush pulse", 64'(mult_pulses - p_m), 64'(1));
    cyc();
    respond(9, 0);
    check("start flush op_ready", 64'(op_ready), 64'(1));

    // Flush in DONE drops result
    issue(0, 5, 5, 10);
    cyc();
    respond(25, 0);
    check("done flush pre",  64'(wb_valid), 64'(1));
    flush = 1; cyc(); flush = 0;
    check("done flush wbv",  64'(wb_valid), 64'(0));
    check("done flush rdy",  64'(op_ready), 64'(1));

    // Async reset mid-BUSY, then a normal op
    issue(0, 6, 7, 11);
    cyc(); cyc();
    #2 reset_n = 0;
    #1;
    check("areset op_ready", 64'(op_ready),  64'(1));
    check("areset stall",    64'(stall),     64'(0));
    check("areset mult",     64'(ctrl_MULT), 64'(0));
    check("areset opA",      64'(md_operandA), 64'(0));
    check("areset wb_data",  64'(wb_data),   64'(0));
    @(negedge clock);
    reset_n = 1;
    cyc();
    issue(1, 7, 3, 2);
    cyc();
    respond(2, 0);
    check("post rst wb_valid", 64'(wb_valid), 64'(1));
    check("post rst wb_data",  64'(wb_data),  64'd2);
    ack();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
